// File: rtl/div_iter_unit_pkg.sv
// Shared definitions for the execute-stage divider: opcodes, FSM states,
// architectural constants and a magnitude helper.
package div_iter_unit_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] data_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam data_t DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam data_t INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Two's complement magnitude for signed operands; INT_MIN maps to 2^31 as unsigned.
  function automatic data_t f_mag(input data_t v, input logic is_signed);
    if (is_signed && v[DATA_W-1]) begin
      f_mag = ~v + 32'd1;
    end else begin
      f_mag = v;
    end
  endfunction

endpackage

// File: rtl/div_core_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_core_step
  import div_iter_unit_pkg::*;
(
  input  data_t i_rem,
  input  data_t i_q,
  input  data_t i_div,
  output data_t o_rem,
  output data_t o_q
);

  logic [32:0] w_shift;
  logic        w_ge;

  // 33-bit compare keeps a full-scale unsigned divisor from overflowing.
  always_comb begin
    w_shift = {i_rem, i_q[31]};
    w_ge    = (w_shift >= {1'b0, i_div});
    if (w_ge) begin
      o_rem = w_shift[31:0] - i_div;
    end else begin
      o_rem = w_shift[31:0];
    end
    o_q = {i_q[30:0], w_ge};
  end

endmodule

// File: rtl/div_iter_unit_chk.sv
// Protocol checks on the request channel of the iterative divider.
module div_iter_unit_chk (
  input logic       i_clk,
  input logic       i_rst,
  input logic       i_req_valid,
  input logic       i_req_ready,
  input logic [2:0] i_funct3
);

  a_funct3_legal: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_req_valid && i_req_ready) |-> i_funct3[2])
    else $error("div_iter_unit: request presented with non-divide funct3 %b", i_funct3);

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit with valid/ready request and
// response channels; corner cases resolve in one cycle, others take 32 steps.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  data_t            r_rem, r_q, r_div;
  logic             r_sel_rem, r_neg_q, r_neg_r;
  logic             r_req_ready, r_resp_valid, r_busy;
  data_t            r_resp_data;

  logic  w_accept, w_signed, w_b_zero, w_ovf, w_special, w_neg_q, w_neg_r;
  data_t w_a_mag, w_b_mag, w_spec_data, w_rem_nxt, w_q_nxt, w_fix_data;

  div_core_step u_step (
    .i_rem (r_rem),
    .i_q   (r_q),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_q   (w_q_nxt)
  );

  div_iter_unit_chk u_chk (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_ready (r_req_ready),
    .i_funct3    (req_funct3)
  );

  // Request decode: operand magnitudes, sign flags and one-cycle corner cases.
  always_comb begin
    w_accept  = req_valid && r_req_ready && req_funct3[2] && !flush;
    w_signed  = ~req_funct3[0];
    w_a_mag   = f_mag(req_a, w_signed);
    w_b_mag   = f_mag(req_b, w_signed);
    w_b_zero  = (req_b == 32'd0);
    w_ovf     = w_signed && (req_a == INT_MIN) && (req_b == 32'hFFFF_FFFF);
    w_special = w_b_zero || w_ovf;
    w_neg_q   = w_signed && (req_a[31] ^ req_b[31]) && !w_b_zero;
    w_neg_r   = w_signed && req_a[31];
    if (w_b_zero) begin
      w_spec_data = req_funct3[1] ? req_a : DIV_ZERO_Q;
    end else begin
      w_spec_data = req_funct3[1] ? 32'd0 : INT_MIN;
    end
    if (r_sel_rem) begin
      w_fix_data = r_neg_r ? (~w_rem_nxt + 32'd1) : w_rem_nxt;
    end else begin
      w_fix_data = r_neg_q ? (~w_q_nxt + 32'd1) : w_q_nxt;
    end
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_nxt = w_special ? DONE : CALC;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        CALC: begin
          if (r_cnt == '0) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = CALC;
          end
        end
        DONE: begin
          if (resp_ready) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DONE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rem        <= 32'd0;
      r_q          <= 32'd0;
      r_div        <= 32'd0;
      r_sel_rem    <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_resp_data  <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == DONE);
      r_busy       <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt     <= CNT_W'(31);
            r_rem     <= 32'd0;
            r_q       <= w_a_mag;
            r_div     <= w_b_mag;
            r_sel_rem <= req_funct3[1];
            r_neg_q   <= w_neg_q;
            r_neg_r   <= w_neg_r;
            if (w_special) begin
              r_resp_data <= w_spec_data;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          // Final step: sign-correct straight into the response register.
          if (r_cnt == '0) begin
            r_resp_data <= w_fix_data;
          end
        end
        DONE:    r_resp_data <= r_resp_data;
        default: r_resp_data <= r_resp_data;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign busy       = r_busy;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit: arithmetic vectors, corner
// cases, backpressure, flush and mid-operation reset.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [2:0]  req_funct3;
  logic [31:0] req_a, req_b, resp_data;

  int n_cmp = 0;
  int n_err = 0;

  localparam int NV = 15;
  // funct3, a, b, expected result, expected cycles from accept edge to resp_valid
  logic [2:0]  v_f   [NV] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111,
                              3'b101, 3'b100, 3'b100, 3'b111, 3'b110, 3'b100, 3'b110};
  logic [31:0] v_a   [NV] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                              32'd5, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] v_b   [NV] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                              32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1,
                              32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] v_exp [NV] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1,
                              32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
  int          v_lat [NV] = '{32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 0, 0, 0, 0, 0};

  div_iter_unit dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Issues one request from IDLE and waits (bounded) for resp_valid.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = f; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    d = resp_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_data !== 32'd0) begin n_err++; $display("FAIL reset resp_data: got %h want 0", resp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors(input int lo, input int hi);
    logic [31:0] d;
    int          lat;
    for (int i = lo; i <= hi; i++) begin
      run_op(v_f[i], v_a[i], v_b[i], d, lat);
      n_cmp++; if (d !== v_exp[i]) begin n_err++; $display("FAIL vec%0d data: got %h want %h", i, d, v_exp[i]); end
      n_cmp++; if (lat != v_lat[i]) begin n_err++; $display("FAIL vec%0d latency: got %0d want %0d", i, lat, v_lat[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    int          lat;
    resp_ready = 1'b0;
    run_op(3'b101, 32'd1000, 32'd10, d, lat);
    n_cmp++; if (d !== 32'd100) begin n_err++; $display("FAIL bp data: got %h want %h", d, 32'd100); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (resp_data !== 32'd100) begin n_err++; $display("FAIL bp hold%0d data: got %h want %h", i, resp_data, 32'd100); end
      n_cmp++; if (busy !== 1'b1 || resp_valid !== 1'b1) begin n_err++; $display("FAIL bp hold%0d busy/valid: got %b%b want 11", i, busy, resp_valid); end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp handshake req_ready: got %b want 0", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp after ready/valid/busy: got %b%b%b want 100", req_ready, resp_valid, busy);
    end
  endtask

  task automatic test_flush_rst();
    logic [31:0] d;
    int          lat;
    logic        saw_valid;
    saw_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b101; req_a = 32'd1000; req_b = 32'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      saw_valid |= resp_valid;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      n_err++; $display("FAIL flush state ready/busy/valid: got %b%b%b want 100", req_ready, busy, resp_valid);
    end
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush blocks accept busy: got %b want 0", busy); end
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      saw_valid |= resp_valid;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst mid-op ready/valid/busy: got %b%b%b want 100", req_ready, resp_valid, busy);
    end
    n_cmp++; if (resp_data !== 32'd0) begin n_err++; $display("FAIL rst mid-op data: got %h want 0", resp_data); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      saw_valid |= resp_valid;
    end
    n_cmp++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL aborted op resp_valid seen: got %b want 0", saw_valid); end
    run_op(3'b101, 32'd9, 32'd3, d, lat);
    n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL post-abort data: got %h want %h", d, 32'd3); end
    n_cmp++; if (lat != 32) begin n_err++; $display("FAIL post-abort latency: got %0d want 32", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_funct3 = 3'b101; req_a = 32'd0; req_b = 32'd0;
    test_reset();
    test_vectors(0, 9);
    test_vectors(10, NV - 1);
    test_backpressure();
    test_flush_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle iterative RV32M divide/remainder unit in the execute stage.
- Responds to DIV, DIVU, REM and REMU requests issued by the execute-stage controller over a valid/ready request channel and a valid/ready response channel.
- Replaces the single-cycle divider path so that timing closes.
- Handles every RISC-V architectural corner case internally and stalls the pipeline only through its handshake.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter (must hold XLEN).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  pipeline flush; aborts any in-flight operation
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_funct3  input  3  funct3 of the instruction: DIV=100, DIVU=101, REM=110, REMU=111
- req_a  input  XLEN  rs1, the dividend
- req_b  input  XLEN  rs2, the divisor
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts the result
- resp_data  output  XLEN  quotient or remainder
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_data=0, busy=0, state=IDLE. Reset applies mid-operation identically.
- Accept: a request is accepted on a cycle T where req_valid && req_ready. The unit latches funct3 and both operands, and sets signed = ~funct3[0].
- Magnitudes: for signed ops, |a| and |b| are taken (two's complement negate when bit 31 is set). For unsigned ops, the operands are used as-is.
- neg_q = signed && (a[31]^b[31]) && b!=0. neg_r = signed && a[31].
- Special cases, decided at T, go to DONE at T+1 with no iteration:
  - b==0: quotient=32'hFFFF_FFFF; remainder=a (unmodified).
  - signed && a==32'h8000_0000 && b==32'hFFFF_FFFF: quotient=32'h8000_0000; remainder=0.
- Normal case: IDLE -> CALC. Radix-2 restoring division, one bit per cycle, 32 iterations.
  - Each iteration: rem = {rem[30:0], q[31]}; q <<= 1; if rem >= |b| then rem -= |b| and q[0] = 1.
  - The remainder register is 33 bits for the compare/subtract.
- Counter: loads 31 at accept and decrements each CALC cycle; on the cycle it reads 0, the state moves to DONE.
- Sign fix and output register: on entry to DONE, the quotient is negated if neg_q and the remainder is negated if neg_r. resp_data selects the quotient for funct3[1]=0 and the remainder for funct3[1]=1.
- Latency: resp_valid rises at T+33 in the normal case and at T+1 in special cases.
- DONE: resp_valid=1. resp_data is held stable until resp_valid && resp_ready, then the unit returns to IDLE the next cycle.
- Back-to-back: there is no accept in the handshake cycle itself; req_ready rises the cycle after the response handshake.
- flush: takes priority over everything except rst. In any state it forces IDLE next cycle with resp_valid=0. A request presented together with flush in IDLE is not accepted.
- Invalid funct3 (bit 2 = 0): not accepted; req_ready is still high, but the controller must not present it. An assertion flags a violation.
- Unsigned 0xFFFF_FFFF operands must not overflow: this is why the compare is 33 bits wide.

Decomposition:
- Add to the shared defines package: the DIV/DIVU/REM/REMU funct3 constants (already present), a div_state_t enum {IDLE, CALC, DONE}, and the constants DIV_ZERO_Q=32'hFFFF_FFFF and INT_MIN=32'h8000_0000. Reuse data_t.
- One sub-module, div_core_step: combinational single-iteration shift/compare/subtract, taking {rem, q, divisor} and producing {rem', q'}. This lets the radix later be raised by instancing it twice.

Test Plan:
- DIVU 100/7, resp_ready tied high -> resp_valid at T+33, resp_data=14. REMU same operands -> 2.
- DIV -7/2 (0xFFFF_FFF9, 2) -> 0xFFFF_FFFD (-3). REM same -> 0xFFFF_FFFF (-1), remainder sign follows dividend.
- DIV 5/0 -> 0xFFFF_FFFF at T+1. REMU 5/0 -> 5 at T+1. DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000 and REM -> 0, both at T+1.
- DIVU 0xFFFF_FFFF/1 -> 0xFFFF_FFFF. REMU 0xFFFF_FFFF/0xFFFF_FFFE -> 1.
- Backpressure: resp_ready low for 5 cycles after resp_valid -> resp_data stable and busy=1 throughout. The handshake cycle returns the unit to IDLE and req_ready=1 the next cycle.
- Flush at iteration 10, then rst asserted during CALC -> IDLE next cycle, resp_valid never asserted, all outputs at reset values. A new DIVU 9/3 afterwards returns 3.
